// File: rtl/avg_sched_pkg.sv
// Shared types and default widths for the dual-ROM averaging sequencer.
package avg_sched_pkg;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int THRESH_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EVAL  = 2'd2,
        SHOW  = 2'd3
    } state_t;
endpackage

// File: rtl/edge_det_sync.sv
// Registered rising-edge detector for a level input already in the clk domain.
module edge_det_sync (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic rise
);
    logic din_q;
    logic din_d;

    assign din_d = din;
    assign rise  = din & ~din_q;

    always_ff @(posedge clk) begin
        if (clr) din_q <= 1'b0;
        else     din_q <= din_d;
    end
endmodule

// File: rtl/avg_filter_sched.sv
// Scans both ROMs, stores rounded averages above THRESH compactly in RAM,
// then steps the RAM read address through the stored entries on each tick.
module avg_filter_sched
    import avg_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int THRESH = THRESH_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              btn,
    input  logic              tick,
    input  logic [DATA_W-1:0] rom_a,
    input  logic [DATA_W-1:0] rom_b,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W:0]   stored_cnt,
    output logic              busy,
    output logic              done
);
    localparam logic [DATA_W-1:0] THR = DATA_W'(THRESH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] disp_idx_q, disp_idx_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] avg_q, avg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              start;
    logic [DATA_W:0]   sum_w;
    logic              pass_w;
    logic              disp_last_w;

    edge_det_sync u_btn_edge (
        .clk  (clk),
        .clr  (clr),
        .din  (btn),
        .rise (start)
    );

    // One extra bit keeps the carry of a+b+1 before halving.
    assign sum_w       = {1'b0, rom_a} + {1'b0, rom_b} + {{DATA_W{1'b0}}, 1'b1};
    assign pass_w      = avg_q > THR;
    assign disp_last_w = {1'b0, disp_idx_q} == (cnt_q - 1'b1);

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        disp_idx_d = disp_idx_q;
        cnt_d      = cnt_q;
        avg_d      = avg_q;
        case (state_q)
            IDLE, SHOW: begin
                if (start) begin
                    rd_ptr_d   = '0;
                    wr_ptr_d   = '0;
                    disp_idx_d = '0;
                    cnt_d      = '0;
                    state_d    = FETCH;
                end else if (state_q == SHOW && tick && cnt_q != '0) begin
                    disp_idx_d = disp_last_w ? '0 : disp_idx_q + 1'b1;
                end
            end
            FETCH: begin
                avg_d   = DATA_W'(sum_w >> 1);
                state_d = EVAL;
            end
            EVAL: begin
                if (pass_w) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
                if (rd_ptr_q == {ADDR_W{1'b1}}) begin
                    disp_idx_d = '0;
                    state_d    = SHOW;
                end else begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    state_d  = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == FETCH) || (state_d == EVAL);
        done_d = (state_d == SHOW);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            disp_idx_q <= '0;
            cnt_q      <= '0;
            avg_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            disp_idx_q <= disp_idx_d;
            cnt_q      <= cnt_d;
            avg_q      <= avg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // The write is suppressed in a clr cycle so a mid-scan reset leaves RAM alone.
    assign ram_we     = (state_q == EVAL) && pass_w && !clr;
    assign ram_addr   = (state_q == EVAL) ? wr_ptr_q : disp_idx_q;
    assign rom_addr   = rd_ptr_q;
    assign ram_wdata  = avg_q;
    assign stored_cnt = cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule
